// File: rtl/nr_div_host.sv
// nr_div_host: host-side driver that streams a wide dividend/divisor to NR_Div and assembles the quotient
// Ports: clk, rst_n (async active-low); start/dividend/divisor request side; busy/done/err status;
//        quotient assembled result; dividend_out/divisor_out/valid_out/data_vld_out toward the divider;
//        quotient_in/data_vld_in beats back from the divider.
module nr_div_host #(
  parameter int N       = 4096,
  parameter int M       = 2048,
  parameter int Block   = 128,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N-1:0]     dividend,
  input  logic [M-1:0]     divisor,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [M-1:0]     quotient,
  output logic [Block-1:0] dividend_out,
  output logic [Block-1:0] divisor_out,
  output logic             valid_out,
  output logic             data_vld_out,
  input  logic [Block-1:0] quotient_in,
  input  logic             data_vld_in
);
  localparam int NB = N / Block;
  localparam int MB = M / Block;
  localparam int KW = $clog2(NB + 1);
  localparam int JW = $clog2(MB + 1);
  localparam int TW = $clog2(TIMEOUT + 2);

  if (N % Block != 0 || M % Block != 0 || M > N) begin : g_bad_params
    $error("nr_div_host: N and M must be multiples of Block and M <= N");
  end

  typedef enum logic [1:0] {IDLE, START, SEND, WAIT} state_t;

  state_t           state_q;
  logic [N-1:0]     dvd_q;
  logic [M-1:0]     dvs_q;
  logic [M-1:0]     quotient_q;
  logic [Block-1:0] dvd_out_q, dvs_out_q;
  logic [KW-1:0]    k_q;
  logic [JW-1:0]    j_q;
  logic [TW-1:0]    wd_q;
  logic             busy_q, done_q, err_q, valid_q, dvld_q;

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign quotient     = quotient_q;
  assign dividend_out = dvd_out_q;
  assign divisor_out  = dvs_out_q;
  assign valid_out    = valid_q;
  assign data_vld_out = dvld_q;

  // Operands are shifted left one block per beat so the next MSB block is always on top;
  // the divisor runs out of data after MB beats and naturally yields zero beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dvd_q      <= '0;
      dvs_q      <= '0;
      quotient_q <= '0;
      dvd_out_q  <= '0;
      dvs_out_q  <= '0;
      k_q        <= '0;
      j_q        <= '0;
      wd_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      dvld_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          // the cycle showing done/err is already IDLE, but a start there is not accepted
          if (start && !done_q && !err_q) begin
            dvd_q      <= dividend;
            dvs_q      <= divisor;
            quotient_q <= '0;
            busy_q     <= 1'b1;
            valid_q    <= 1'b1;
            state_q    <= START;
          end
        end
        START: begin
          dvld_q    <= 1'b1;
          dvd_out_q <= dvd_q[N-1 -: Block];
          dvs_out_q <= dvs_q[M-1 -: Block];
          dvd_q     <= dvd_q << Block;
          dvs_q     <= dvs_q << Block;
          k_q       <= KW'(1);
          state_q   <= SEND;
        end
        SEND: begin
          if (k_q == KW'(NB)) begin
            dvld_q    <= 1'b0;
            dvd_out_q <= '0;
            dvs_out_q <= '0;
            j_q       <= '0;
            wd_q      <= '0;
            state_q   <= WAIT;
          end else begin
            dvd_out_q <= dvd_q[N-1 -: Block];
            dvs_out_q <= dvs_q[M-1 -: Block];
            dvd_q     <= dvd_q << Block;
            dvs_q     <= dvs_q << Block;
            k_q       <= k_q + 1'b1;
          end
        end
        WAIT: begin
          if (data_vld_in) begin
            quotient_q[j_q*Block +: Block] <= quotient_in;
            wd_q <= '0;
            j_q  <= j_q + 1'b1;
            if (j_q == JW'(MB - 1)) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else if (TIMEOUT != 0) begin
            wd_q <= wd_q + 1'b1;
            if (wd_q == TW'(TIMEOUT - 1)) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nr_div_host.sv
// tb_nr_div_host: scoreboard bench for nr_div_host with a stub quotient responder
module tb_nr_div_host;
  localparam int N  = 4096;
  localparam int M  = 2048;
  localparam int BL = 128;
  localparam int TO = 50;
  localparam int NB = N / BL;
  localparam int MB = M / BL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          data_vld_in = 1'b0;
  logic [N-1:0]  dividend = '0;
  logic [M-1:0]  divisor = '0;
  logic [BL-1:0] quotient_in = '0;
  logic          busy, done, err, valid_out, data_vld_out;
  logic [M-1:0]  quotient;
  logic [BL-1:0] dividend_out, divisor_out;

  nr_div_host #(.N(N), .M(M), .Block(BL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .err(err), .quotient(quotient),
    .dividend_out(dividend_out), .divisor_out(divisor_out), .valid_out(valid_out),
    .data_vld_out(data_vld_out), .quotient_in(quotient_in), .data_vld_in(data_vld_in)
  );

  typedef struct {
    int            kind;
    int            cyc;
    logic [BL-1:0] a;
    logic [BL-1:0] b;
    logic [M-1:0]  q;
  } ev_t;

  ev_t          sb[$];
  ev_t          me;
  int           mk;
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  logic [M-1:0] qexp;
  logic [N-1:0] d1, d2;
  logic [M-1:0] s1, s2;
  int           p, tl;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [BL-1:0] act, input logic [BL-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic void push(int k, int c, logic [BL-1:0] a, logic [BL-1:0] b, logic [M-1:0] q);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.a    = a;
    e.b    = b;
    e.q    = q;
    sb.push_back(e);
  endfunction

  // kinds: 0 start pulse, 1 operand beat, 2 done, 3 err
  always @(negedge clk) begin
    if (rst_n && (valid_out || data_vld_out || done || err)) begin
      mk = err ? 3 : done ? 2 : data_vld_out ? 1 : 0;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event cyc=%0d got kind=%0d want none", cyc, mk);
      end else begin
        me = sb.pop_front();
        chk("ev_kind", BL'(mk), BL'(me.kind));
        chk("ev_cycle", BL'(cyc), BL'(me.cyc));
        chk("one_strobe", BL'(int'(valid_out) + int'(data_vld_out) + int'(done) + int'(err)), BL'(1));
        if (mk < 2) begin
          chk("dividend_out", dividend_out, me.a);
          chk("divisor_out", divisor_out, me.b);
          chk("busy_active", BL'(busy), BL'(1));
        end else begin
          chk("busy_at_end", BL'(busy), BL'(0));
          for (int j = 0; j < MB; j++) chk("quotient_block", quotient[j*BL +: BL], me.q[j*BL +: BL]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic issue(input logic [N-1:0] dv, input logic [M-1:0] ds, output int pc);
    dividend = dv;
    divisor  = ds;
    start    = 1'b1;
    pc       = cyc;
    qexp     = '0;
    push(0, pc + 1, '0, '0, '0);
    for (int k = 0; k < NB; k++) begin
      if (k < MB) push(1, pc + 2 + k, dv[(NB-1-k)*BL +: BL], ds[(MB-1-k)*BL +: BL], '0);
      else push(1, pc + 2 + k, dv[(NB-1-k)*BL +: BL], '0, '0);
    end
    step();
    start    = 1'b0;
    dividend = ~dv;
    divisor  = ~ds;
    chk("quotient_cleared", BL'(|quotient), BL'(0));
    chk("busy_after_start", BL'(busy), BL'(1));
  endtask

  // A junk beat lands in the last SEND cycle and must be dropped; then nb beats with 3-cycle gaps.
  task automatic respond(input int pc, input int nb, input int base, output int last);
    go_to(pc + NB + 1);
    data_vld_in = 1'b1;
    quotient_in = '1;
    step();
    data_vld_in = 1'b0;
    quotient_in = '0;
    last = cyc;
    for (int j = 0; j < nb; j++) begin
      data_vld_in = 1'b1;
      quotient_in = BL'(base + j);
      qexp[j*BL +: BL] = BL'(base + j);
      last = cyc;
      step();
      data_vld_in = 1'b0;
      if (j < nb - 1) begin
        for (int g = 0; g < 3; g++) begin
          start = (j == 2 && g == 0);
          step();
        end
      end
      start = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NB; i++) begin
      d1[i*BL +: BL] = BL'(i);
      d2[i*BL +: BL] = {32'hA5A5_0000 + 32'(7 * i), 32'h0, 32'hFFFF_0000 | 32'(i), 32'h1234_5678};
    end
    for (int i = 0; i < MB; i++) begin
      s1[i*BL +: BL] = BL'(100 + i);
      s2[i*BL +: BL] = {32'hC3C3_0000 + 32'(i), 32'hDEAD_BEEF, 32'h0, 32'(i * 11)};
    end
    repeat (2) step();
    chk("rst_busy", BL'(busy), BL'(0));
    chk("rst_done", BL'(done), BL'(0));
    chk("rst_err", BL'(err), BL'(0));
    chk("rst_valid_out", BL'(valid_out), BL'(0));
    chk("rst_data_vld_out", BL'(data_vld_out), BL'(0));
    chk("rst_dividend_out", dividend_out, '0);
    chk("rst_divisor_out", divisor_out, '0);
    chk("rst_quotient", BL'(|quotient), BL'(0));
    rst_n = 1'b1;
    step();

    // ordered blocks; start pulses in SEND and WAIT must be ignored
    issue(d1, s1, p);
    go_to(p + 10);
    start = 1'b1;
    step();
    start = 1'b0;
    respond(p, MB, 'h10, tl);
    push(2, tl + 1, '0, '0, qexp);
    // start in the done cycle is ignored; one cycle later it is accepted
    start = 1'b1;
    step();
    issue(d2, s2, p);
    respond(p, MB, 'h200, tl);
    push(2, tl + 1, '0, '0, qexp);
    repeat (3) step();

    // watchdog: five beats then silence
    issue(d1, s2, p);
    respond(p, 5, 'h30, tl);
    push(3, tl + TO + 1, '0, '0, qexp);
    go_to(tl + TO + 6);
    chk("busy_after_err", BL'(busy), BL'(0));

    // async reset in the middle of SEND, then a fresh full transfer
    issue(d2, s1, p);
    go_to(p + 12);
    rst_n = 1'b0;
    #1;
    chk("midrst_data_vld_out", BL'(data_vld_out), BL'(0));
    chk("midrst_dividend_out", dividend_out, '0);
    chk("midrst_divisor_out", divisor_out, '0);
    chk("midrst_busy", BL'(busy), BL'(0));
    chk("midrst_quotient", BL'(|quotient), BL'(0));
    sb.delete();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) step();
    issue(d1, s1, p);
    respond(p, MB, 'h40, tl);
    push(2, tl + 1, '0, '0, qexp);
    repeat (4) step();
    chk("scoreboard_drained", BL'(sb.size()), BL'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nr_div_host.md
Name: nr_div_host

Overview:
- Host-side driver for the block-serial NR_Div interface.
- Accepts one wide dividend and one wide divisor in parallel, issues the divider's start pulse, and streams both operands as Block-bit beats MSB-first.
- Collects the quotient beats returned LSB-first and presents the assembled M-bit quotient with a done pulse.
- Sits between the L-function control logic and NR_Div.

Parameters:
- N, 4096, dividend width in bits; multiple of Block.
- M, 2048, divisor and quotient width in bits; multiple of Block; M <= N.
- Block, 128, beat width in bits.
- TIMEOUT, 65535, max idle cycles in WAIT between quotient beats before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled in IDLE only.
- dividend  in  N  operand, latched on accepted start.
- divisor  in  M  operand, latched on accepted start.
- busy  out  1  high from accepted start until done/err.
- done  out  1  one-cycle pulse when quotient is valid.
- err  out  1  one-cycle pulse on watchdog abort.
- quotient  out  M  assembled result; holds until next accepted start.
- dividend_out  out  Block  dividend beat to divider.
- divisor_out  out  Block  divisor beat to divider.
- valid_out  out  1  one-cycle start pulse to divider.
- data_vld_out  out  1  beat qualifier for dividend_out/divisor_out.
- quotient_in  in  Block  quotient beat from divider.
- data_vld_in  in  1  quotient beat qualifier.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, quotient 0, FSM in IDLE, beat counters 0.
- Derived constants: NB = N/Block, MB = M/Block.

FSM states:
- IDLE: start=1 latches dividend/divisor, sets busy, and moves to START. start=0 stays in IDLE.
- START: valid_out=1 for exactly one cycle; data_vld_out=0; both data outputs 0. Next state SEND.
- SEND: NB consecutive cycles with data_vld_out=1 and no gaps. Next state WAIT.
  - Beat k (0..NB-1): dividend_out = latched dividend[(NB-1-k)*Block +: Block].
  - Beat k: divisor_out = latched divisor[(MB-1-k)*Block +: Block] for k < MB, else 0.
- WAIT: each cycle with data_vld_in=1 captures quotient_in into bits [j*Block +: Block], j = 0..MB-1, LSB-first.
  - After beat MB-1: done=1 for one cycle, busy drops in the same cycle, return to IDLE.

Output timing and handshakes:
- Latency from accepted start: valid_out at cycle +1; first beat at +2; last beat at +NB+1.
- data_vld_in outside WAIT is ignored and does not advance j. A beat arriving in the same cycle SEND completes is ignored.
- quotient register is cleared to 0 on accepted start. Partial quotient bits are visible while in WAIT; they are valid only at done.
- start while busy is ignored with no queuing. start in the same cycle as done is also ignored; the FSM only accepts start from IDLE.

Watchdog:
- If TIMEOUT != 0, a counter runs in WAIT and resets on every accepted quotient beat.
- When the counter reaches TIMEOUT: err=1 for one cycle, busy=0, return to IDLE. quotient keeps its partial content; done is not asserted.

Other rules:
- Reset asserted mid-operation: immediate return to reset values; no pulses are emitted afterwards.
- dividend/divisor inputs may change after acceptance with no effect on the transfer in progress.
- Elaboration error if N%Block != 0, M%Block != 0, or M > N.

Test Plan:
- Defaults; dividend block i = i (i = 0..31, block 0 least significant); divisor block i = 100+i. Expect: valid_out one cycle after start; beat 0 dividend_out=31, divisor_out=115; beat 15 divisor_out=100; beat 16 divisor_out=0; beat 31 dividend_out=0; 32 contiguous data_vld_out cycles.
- Stub responder returns 16 beats with values 0x10..0x1F, 3 idle cycles between beats. Expect quotient block j = 0x10+j, a single done pulse after the 16th beat, and busy low in the same cycle.
- Same cycle-level checks with random operands against an NR_Div instance. Expect quotient == dividend/divisor. Example: dividend = 2^4000, divisor = 2^2000+1.
- start pulsed during SEND and again during WAIT. Expect no restart, no second valid_out, and beat sequence unchanged. A start one cycle after done is accepted.
- TIMEOUT=50, responder sends 5 beats then stops. Expect err pulse 50 cycles after beat 5, busy=0, no done, quotient blocks 0..4 holding the received data.
- rst_n low for 2 cycles at SEND beat 10. Expect all outputs 0 immediately and no further data_vld_out. A new start after release produces a full fresh sequence from beat 0.
